// File: rtl/fsm_ctrl_pkg.sv
// Shared types and default widths for the FSM run controller.
package fsm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        SETTLE,
        DONE
    } state_t;

    localparam int OUT_W_DEF   = 5;
    localparam int CYCLE_W_DEF = 32;

    // Width of the phase counter that times the reset and settle windows.
    localparam int PHASE_W     = 16;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count
// compare against a caller-supplied value.
module run_cycle_counter #(
    parameter int W = 32
) (
    input  logic         clk_p,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         at_term
);

    localparam logic [W-1:0] ONE = W'(1);

    // Clear wins over enable; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk_p) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/fsm_run_controller.sv
// Initiator for the start/ready handshake: resets the target FSM, raises
// start, measures cycles until ready rises, then samples out/correct.
// Optional run statistics (run_count / pass_count) are built when the
// RUN_STATS_EN macro is defined.
module fsm_run_controller
    import fsm_ctrl_pkg::*;
#(
    parameter int OUT_W          = OUT_W_DEF,
    parameter int CYCLE_W        = CYCLE_W_DEF,
    parameter int RST_CYCLES     = 2,
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk_p,
    input  logic               reset,
    input  logic               go,
    input  logic               dut_ready,
    input  logic [OUT_W-1:0]   dut_out,
    input  logic               dut_correct,
    output logic               dut_reset,
    output logic               dut_start,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycles,
    output logic [OUT_W-1:0]   result_out,
    output logic               result_correct
`ifdef RUN_STATS_EN
    ,
    output logic [15:0]        run_count,
    output logic [15:0]        pass_count
`endif
);

    // Timeout fires on the RUN cycle whose increment lands on TIMEOUT_CYCLES-1.
    localparam logic [CYCLE_W-1:0] TO_TERM  = CYCLE_W'(TIMEOUT_CYCLES - 2);
    localparam logic [PHASE_W-1:0] RST_TERM = PHASE_W'(RST_CYCLES - 1);
    localparam logic [PHASE_W-1:0] SET_TERM = PHASE_W'(SETTLE_CYCLES - 1);

    state_t state, state_n;

    logic               ready_q;
    logic               rise;
    logic               cyc_clr, cyc_en, cyc_tc;
    logic [PHASE_W-1:0] ph_cnt, ph_term;
    logic               ph_clr, ph_en, ph_tc;
    logic               dut_reset_n, dut_start_n, timeout_n, res_ld;
    logic               unused_ph;

    assign rise    = dut_ready & ~ready_q;
    assign ph_term = (state == RST) ? RST_TERM : SET_TERM;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // The phase count is only ever consumed through its terminal compare.
    assign unused_ph = ^ph_cnt;

    run_cycle_counter #(.W(CYCLE_W)) u_cyc (
        .clk_p   (clk_p),
        .reset   (reset),
        .clr     (cyc_clr),
        .en      (cyc_en),
        .term    (TO_TERM),
        .count   (cycles),
        .at_term (cyc_tc)
    );

    run_cycle_counter #(.W(PHASE_W)) u_phase (
        .clk_p   (clk_p),
        .reset   (reset),
        .clr     (ph_clr),
        .en      (ph_en),
        .term    (ph_term),
        .count   (ph_cnt),
        .at_term (ph_tc)
    );

    // Next-state and next-output decode; everything holds unless a state acts.
    always_comb begin
        state_n     = state;
        dut_reset_n = dut_reset;
        dut_start_n = dut_start;
        timeout_n   = timeout;
        res_ld      = 1'b0;
        cyc_clr     = 1'b0;
        cyc_en      = 1'b0;
        ph_clr      = 1'b0;
        ph_en       = 1'b0;
        case (state)
            IDLE: begin
                dut_reset_n = 1'b0;
                if (go) begin
                    state_n     = RST;
                    timeout_n   = 1'b0;
                    dut_reset_n = 1'b1;
                    cyc_clr     = 1'b1;
                    ph_clr      = 1'b1;
                end
            end
            RST: begin
                dut_reset_n = 1'b1;
                if (ph_tc) begin
                    state_n     = RUN;
                    dut_reset_n = 1'b0;
                    dut_start_n = 1'b1;
                    cyc_clr     = 1'b1;
                end else begin
                    ph_en = 1'b1;
                end
            end
            RUN: begin
                cyc_en = 1'b1;
                if (rise) begin
                    state_n = SETTLE;
                    ph_clr  = 1'b1;
                end else if (cyc_tc) begin
                    state_n     = IDLE;
                    timeout_n   = 1'b1;
                    dut_start_n = 1'b0;
                end
            end
            SETTLE: begin
                if (ph_tc) begin
                    state_n     = DONE;
                    res_ld      = 1'b1;
                    dut_start_n = 1'b0;
                end else begin
                    ph_en = 1'b1;
                end
            end
            DONE: begin
                dut_start_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_p) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered handshake outputs, sampled results and the ready edge history.
    always_ff @(posedge clk_p) begin
        if (reset) begin
            dut_reset      <= 1'b1;
            dut_start      <= 1'b0;
            timeout        <= 1'b0;
            result_out     <= '0;
            result_correct <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            dut_reset <= dut_reset_n;
            dut_start <= dut_start_n;
            timeout   <= timeout_n;
            // Held low through RST, but the RST->RUN edge captures live ready so
            // a level already high at RUN entry does not register as a rise.
            ready_q   <= (state == RST && !ph_tc) ? 1'b0 : dut_ready;
            if (res_ld) begin
                result_out     <= dut_out;
                result_correct <= dut_correct;
            end
        end
    end

`ifdef RUN_STATS_EN
    logic to_evt;
    assign to_evt = (state == RUN) && !rise && cyc_tc;

    // Saturating run/pass tallies; only reset clears them.
    always_ff @(posedge clk_p) begin
        if (reset) begin
            run_count  <= '0;
            pass_count <= '0;
        end else begin
            if ((done || to_evt) && (run_count != '1)) begin
                run_count <= run_count + 16'd1;
            end
            if (done && result_correct && (pass_count != '1)) begin
                pass_count <= pass_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fsm_run_controller.sv
// Directed bench for fsm_run_controller with a short timeout (16 cycles).
module tb_fsm_run_controller;

    logic        clk_p = 1'b0;
    logic        reset;
    logic        go;
    logic        dut_ready;
    logic [4:0]  dut_out;
    logic        dut_correct;
    logic        dut_reset;
    logic        dut_start;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycles;
    logic [4:0]  result_out;
    logic        result_correct;
`ifdef RUN_STATS_EN
    logic [15:0] run_count;
    logic [15:0] pass_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    fsm_run_controller #(
        .OUT_W          (5),
        .CYCLE_W        (32),
        .RST_CYCLES     (2),
        .SETTLE_CYCLES  (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_p          (clk_p),
        .reset          (reset),
        .go             (go),
        .dut_ready      (dut_ready),
        .dut_out        (dut_out),
        .dut_correct    (dut_correct),
        .dut_reset      (dut_reset),
        .dut_start      (dut_start),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .cycles         (cycles),
        .result_out     (result_out),
        .result_correct (result_correct)
`ifdef RUN_STATS_EN
        ,
        .run_count      (run_count),
        .pass_count     (pass_count)
`endif
    );

    always #5 clk_p = ~clk_p;

    // Count done pulses away from the active edge.
    always @(negedge clk_p) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required end well before");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_p);
        #1;
    endtask

    // Pulse go from IDLE and wait (bounded) for dut_start; ends one step after RUN entry.
    task automatic start_run(input string tag);
        int n;
        go = 1'b1;
        tick;
        go = 1'b0;
        chk({tag, " busy"}, busy, 1);
        chk({tag, " dut_reset"}, dut_reset, 1);
        chk({tag, " timeout_clr"}, timeout, 0);
        chk({tag, " cycles_clr"}, cycles, 0);
        n = 0;
        while (dut_start !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk({tag, " rst_len"}, n, 2);
        chk({tag, " dut_reset_off"}, dut_reset, 0);
    endtask

    // Ready first sampled high on the n-th edge after RUN entry.
    task automatic ready_at(input int n);
        repeat (n - 1) tick;
        dut_ready = 1'b1;
        tick;
    endtask

    // From SETTLE: expect results on the DONE cycle, then back to IDLE.
    task automatic finish_run(input string tag, input int exp_cyc, input int exp_out, input int exp_cor);
        chk({tag, " cycles"}, cycles, exp_cyc);
        chk({tag, " start_settle"}, dut_start, 1);
        tick;
        chk({tag, " done"}, done, 1);
        chk({tag, " result_out"}, result_out, exp_out);
        chk({tag, " result_correct"}, result_correct, exp_cor);
        chk({tag, " start_off"}, dut_start, 0);
        tick;
        chk({tag, " done_off"}, done, 0);
        chk({tag, " idle"}, busy, 0);
        chk({tag, " cycles_hold"}, cycles, exp_cyc);
        dut_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        go          = 1'b0;
        dut_ready   = 1'b0;
        dut_out     = 5'd0;
        dut_correct = 1'b0;
        repeat (3) tick;

        // reset state
        chk("rst dut_reset", dut_reset, 1);
        chk("rst dut_start", dut_start, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst timeout", timeout, 0);
        chk("rst cycles", cycles, 0);
        chk("rst result_out", result_out, 0);
        chk("rst result_correct", result_correct, 0);
        reset = 1'b0;
        tick;
        chk("rel dut_reset", dut_reset, 0);

        // basic run: ready at N=7
        dut_out     = 5'd19;
        dut_correct = 1'b1;
        start_run("t1");
        ready_at(7);
        finish_run("t1", 7, 19, 1);
        chk("t1 done_cnt", done_cnt, 1);

        // ready high through RST, low one cycle, true rise at N=3
        dut_out     = 5'd6;
        dut_correct = 1'b0;
        dut_ready   = 1'b1;
        tick;
        start_run("t2");
        tick;
        dut_ready = 1'b0;
        tick;
        dut_ready = 1'b1;
        tick;
        finish_run("t2", 3, 6, 0);
        chk("t2 done_cnt", done_cnt, 2);

        // timeout after 15 RUN cycles
        start_run("t3");
        repeat (14) tick;
        chk("t3 pre cycles", cycles, 14);
        chk("t3 pre timeout", timeout, 0);
        chk("t3 pre busy", busy, 1);
        tick;
        chk("t3 timeout", timeout, 1);
        chk("t3 busy", busy, 0);
        chk("t3 dut_start", dut_start, 0);
        chk("t3 done", done, 0);
        chk("t3 cycles", cycles, 15);
        tick;
        chk("t3 sticky", timeout, 1);
        chk("t3 done_cnt", done_cnt, 2);
`ifdef RUN_STATS_EN
        chk("stats run_count", run_count, 3);
        chk("stats pass_count", pass_count, 1);
`endif

        // next go clears timeout; rise on the would-be timeout cycle wins
        dut_out     = 5'd31;
        dut_correct = 1'b1;
        start_run("t3b");
        ready_at(15);
        finish_run("t3b", 15, 31, 1);
        chk("t3b timeout", timeout, 0);
        chk("t3b done_cnt", done_cnt, 3);

        // go during RUN and during SETTLE is ignored
        dut_out     = 5'd2;
        dut_correct = 1'b1;
        start_run("t4");
        tick;
        go = 1'b1;
        tick;
        go = 1'b0;
        tick;
        dut_ready = 1'b1;
        tick;
        chk("t4 settle cycles", cycles, 4);
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("t4 done", done, 1);
        chk("t4 cycles", cycles, 4);
        tick;
        chk("t4 done_off", done, 0);
        chk("t4 idle", busy, 0);
        dut_ready = 1'b0;
        tick;
        chk("t4 no_requeue", busy, 0);
        chk("t4 done_cnt", done_cnt, 4);

        // reset 4 cycles into RUN, then a clean run
        dut_out     = 5'd9;
        dut_correct = 1'b1;
        start_run("t5");
        repeat (4) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t5 dut_reset", dut_reset, 1);
        chk("t5 dut_start", dut_start, 0);
        chk("t5 busy", busy, 0);
        chk("t5 cycles", cycles, 0);
        chk("t5 result_out", result_out, 0);
        chk("t5 result_correct", result_correct, 0);
        tick;
        chk("t5 rel dut_reset", dut_reset, 0);
        start_run("t5b");
        ready_at(5);
        finish_run("t5b", 5, 9, 1);
        chk("t5b done_cnt", done_cnt, 5);
`ifdef RUN_STATS_EN
        chk("stats2 run_count", run_count, 1);
        chk("stats2 pass_count", pass_count, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
